// File: rtl/gauss_cdf_rom.vh
// rtl/gauss_cdf_rom.vh - cumulative threshold tables and tail thresholds for sigma indices 1..8
// Entry i sits at [GAUSS_CDF_WIDTH*i +: GAUSS_CDF_WIDTH]; out-of-range indices fall back to the sigma-8 table.

function automatic logic [GAUSS_MAX_SYMBOLS*GAUSS_CDF_WIDTH-1:0] gauss_cdf_pack(input logic [3:0] sig);
    logic [GAUSS_CDF_WIDTH-1:0] t [GAUSS_MAX_SYMBOLS];
    logic [GAUSS_MAX_SYMBOLS*GAUSS_CDF_WIDTH-1:0] p;
    case (sig)
        4'd1: t = '{16'h4000, 16'h9000, 16'hC800, 16'hE400, 16'hF000, 16'hF600, 16'hF900, 16'hFA80,
                    16'hFB40, 16'hFBA0, 16'hFBD0, 16'hFBE8, 16'hFBF4, 16'hFBFA, 16'hFBFD, 16'hFBFE};
        4'd2: t = '{16'h2000, 16'h5000, 16'h7800, 16'h9800, 16'hB000, 16'hC400, 16'hD400, 16'hE000,
                    16'hE800, 16'hEE00, 16'hF200, 16'hF400, 16'hF500, 16'hF580, 16'hF5C0, 16'hF5E0};
        4'd3: t = '{16'h1800, 16'h3C00, 16'h5C00, 16'h7800, 16'h9000, 16'hA400, 16'hB400, 16'hC200,
                    16'hCE00, 16'hD800, 16'hE000, 16'hE600, 16'hEA00, 16'hEC00, 16'hED00, 16'hED80};
        4'd4: t = '{16'h1000, 16'h3000, 16'h5000, 16'h6C00, 16'h8400, 16'h9800, 16'hA800, 16'hB600,
                    16'hC200, 16'hCC00, 16'hD400, 16'hDA00, 16'hDE00, 16'hE100, 16'hE300, 16'hE400};
        4'd5: t = '{16'h0C00, 16'h2400, 16'h3C00, 16'h5400, 16'h6A00, 16'h7E00, 16'h9000, 16'hA000,
                    16'hAE00, 16'hBA00, 16'hC400, 16'hCC00, 16'hD200, 16'hD600, 16'hD900, 16'hDB00};
        4'd6: t = '{16'h0A00, 16'h1E00, 16'h3200, 16'h4600, 16'h5800, 16'h6A00, 16'h7A00, 16'h8800,
                    16'h9600, 16'hA200, 16'hAC00, 16'hB600, 16'hBE00, 16'hC400, 16'hC800, 16'hCA00};
        4'd7: t = '{16'h0900, 16'h1A00, 16'h2C00, 16'h3E00, 16'h4F00, 16'h6000, 16'h6F00, 16'h7E00,
                    16'h8C00, 16'h9800, 16'hA400, 16'hAE00, 16'hB600, 16'hBC00, 16'hC000, 16'hC200};
        default: t = '{16'h0800, 16'h1800, 16'h2800, 16'h3800, 16'h4800, 16'h5800, 16'h6800, 16'h7800,
                       16'h8800, 16'h9800, 16'hA800, 16'hB800, 16'hC800, 16'hD800, 16'hE800, 16'hF000};
    endcase
    p = '0;
    for (int i = 0; i < GAUSS_MAX_SYMBOLS; i++) begin
        p[GAUSS_CDF_WIDTH*i +: GAUSS_CDF_WIDTH] = t[i];
    end
    return p;
endfunction

function automatic logic [GAUSS_CDF_WIDTH-1:0] gauss_tail_threshold(input logic [3:0] sig);
    case (sig)
        4'd1:    return 16'h0100;
        4'd2:    return 16'h0200;
        4'd3:    return 16'h0400;
        4'd4:    return 16'h0800;
        4'd5:    return 16'h1000;
        4'd6:    return 16'h1800;
        default: return 16'h2000;
    endcase
endfunction

// File: rtl/gauss_sampler.sv
// rtl/gauss_sampler.sv - parallel discrete Gaussian sampler by CDF inversion with random sign
// One random word in, one word of PARALLELISM signed coefficients out a cycle later, or nothing if any lane misses the table.
module gauss_sampler #(
    parameter int RANDOM_WIDTH      = 128,
    parameter int PARALLELISM       = 4,
    parameter int GAUSS_MAX_SYMBOLS = 16,
    parameter int GAUSS_CDF_WIDTH   = 16,
    parameter int VALUE_WIDTH       = 13
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               random_valid,
    output logic                               random_ready,
    input  logic [RANDOM_WIDTH-1:0]            random_in,
    input  logic [7:0]                         sigma,
    output logic                               sample_valid,
    output logic [PARALLELISM*VALUE_WIDTH-1:0] coeffs
);

    localparam int LANE_WIDTH = RANDOM_WIDTH / PARALLELISM;
    localparam int CAND_WIDTH = $clog2(GAUSS_MAX_SYMBOLS);
    localparam int HI_WIDTH   = LANE_WIDTH - GAUSS_CDF_WIDTH - 1;

    `include "gauss_cdf_rom.vh"

    logic [3:0]                                   sig_c;
    logic [GAUSS_MAX_SYMBOLS*GAUSS_CDF_WIDTH-1:0] thr_pack;
    logic [GAUSS_CDF_WIDTH-1:0]                   tail;
    logic [GAUSS_CDF_WIDTH-1:0]                   tail_limit;
    logic [GAUSS_CDF_WIDTH-1:0]                   u;
    logic                                         sign;
    logic                                         hit;
    logic [CAND_WIDTH-1:0]                        cand;
    logic [VALUE_WIDTH-1:0]                       mag;
    logic                                         all_ok;
    logic [PARALLELISM*VALUE_WIDTH-1:0]           lanes_pack;
    logic                                         unused_lane_bits;

    logic                                         sample_valid_d, sample_valid_q;
    logic [PARALLELISM*VALUE_WIDTH-1:0]           coeffs_d, coeffs_q;

    always_comb begin
        if (sigma == 8'd0)     sig_c = 4'd1;
        else if (sigma > 8'd8) sig_c = 4'd8;
        else                   sig_c = sigma[3:0];
    end

    always_comb begin
        thr_pack   = gauss_cdf_pack(sig_c);
        tail       = gauss_tail_threshold(sig_c);
        // Tail bound wraps in GAUSS_CDF_WIDTH bits, so a table already near full scale can reject everything past it.
        tail_limit = thr_pack[GAUSS_CDF_WIDTH*(GAUSS_MAX_SYMBOLS-1) +: GAUSS_CDF_WIDTH] + tail;
        u          = '0;
        sign       = 1'b0;
        hit        = 1'b0;
        cand       = '0;
        mag        = '0;
        all_ok     = 1'b1;
        lanes_pack = '0;
        unused_lane_bits = 1'b0;
        for (int l = 0; l < PARALLELISM; l++) begin
            u    = random_in[LANE_WIDTH*l +: GAUSS_CDF_WIDTH];
            sign = random_in[LANE_WIDTH*l + GAUSS_CDF_WIDTH];
            unused_lane_bits = unused_lane_bits ^ (^random_in[LANE_WIDTH*l + GAUSS_CDF_WIDTH + 1 +: HI_WIDTH]);
            hit  = 1'b0;
            cand = '0;
            for (int i = GAUSS_MAX_SYMBOLS - 1; i >= 0; i--) begin
                if (u < thr_pack[GAUSS_CDF_WIDTH*i +: GAUSS_CDF_WIDTH]) begin
                    hit  = 1'b1;
                    cand = CAND_WIDTH'(i);
                end
            end
            if (!hit && (tail != '0) && (u < tail_limit)) begin
                hit  = 1'b1;
                cand = CAND_WIDTH'(GAUSS_MAX_SYMBOLS - 1);
            end
            all_ok = all_ok & hit;
            mag    = {{(VALUE_WIDTH-CAND_WIDTH){1'b0}}, cand};
            lanes_pack[VALUE_WIDTH*l +: VALUE_WIDTH] = (sign && (cand != '0)) ? (-mag) : mag;
        end
    end

    always_comb begin
        sample_valid_d = random_valid & all_ok;
        coeffs_d       = sample_valid_d ? lanes_pack : coeffs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid_q <= 1'b0;
            coeffs_q       <= '0;
        end else begin
            sample_valid_q <= sample_valid_d;
            coeffs_q       <= coeffs_d;
        end
    end

    assign random_ready = ~rst;
    assign sample_valid = sample_valid_q;
    assign coeffs       = coeffs_q;

endmodule

// File: tb/tb_gauss_sampler.sv
// tb/tb_gauss_sampler.sv - directed self-checking bench for gauss_sampler
module tb_gauss_sampler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         random_valid = 1'b0;
    logic         random_ready;
    logic [127:0] random_in = '0;
    logic [7:0]   sigma = 8'd0;
    logic         sample_valid;
    logic [51:0]  coeffs;

    int n_checks = 0;
    int n_errors = 0;
    logic [51:0] last_c = '0;

    localparam logic [15:0] THR4 [16] = '{16'h1000, 16'h3000, 16'h5000, 16'h6C00, 16'h8400, 16'h9800, 16'hA800, 16'hB600,
                                          16'hC200, 16'hCC00, 16'hD400, 16'hDA00, 16'hDE00, 16'hE100, 16'hE300, 16'hE400};
    localparam logic [15:0] TAIL4 = 16'h0800;

    gauss_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .random_valid (random_valid),
        .random_ready (random_ready),
        .random_in    (random_in),
        .sigma        (sigma),
        .sample_valid (sample_valid),
        .coeffs       (coeffs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [51:0] pk(input logic [12:0] c0, input logic [12:0] c1,
                                       input logic [12:0] c2, input logic [12:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Returns {accepted, coefficient} for one lane at sigma 4.
    function automatic logic [13:0] ref_lane4(input logic [31:0] lane);
        logic [15:0] uu;
        logic [15:0] lim;
        int k;
        uu  = lane[15:0];
        lim = THR4[15] + TAIL4;
        k   = 16;
        for (int i = 0; i < 16; i++) begin
            if (k == 16 && uu < THR4[i]) k = i;
        end
        if (k == 16) begin
            if (uu < lim) k = 15;
            else return 14'd0;
        end
        if (lane[16] && k != 0) return {1'b1, 13'(8192 - k)};
        return {1'b1, 13'(k)};
    endfunction

    task automatic send_word(input string tag, input logic [127:0] r, input logic [7:0] s,
                             input bit exp_ok, input logic [51:0] exp_c);
        @(negedge clk);
        random_in    = r;
        sigma        = s;
        random_valid = 1'b1;
        @(posedge clk);
        #1;
        random_valid = 1'b0;
        check({tag, "_valid"}, 64'(sample_valid), 64'(exp_ok));
        check({tag, "_coeffs"}, 64'(coeffs), 64'(exp_ok ? exp_c : last_c));
        if (exp_ok) last_c = exp_c;
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 64'(sample_valid), 64'd0);
    endtask

    initial begin
        logic [31:0]  lanes [4];
        logic [13:0]  r;
        logic [51:0]  ec;
        bit           ok;

        #1;
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_coeffs", 64'(coeffs), 64'd0);
        check("rst_ready", 64'(random_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(random_ready), 64'd1);

        send_word("zero_word", '0, 8'd4, 1'b1, '0);
        send_word("neg_zero", mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000), 8'd4, 1'b1, '0);
        send_word("thr_k", mk(32'h0001_3000, 32'h0000_3000, 32'h0001_E300, 32'hFFFE_0FFF), 8'd4, 1'b1,
                  pk(13'h1FFE, 13'd2, 13'h1FF1, 13'd0));
        send_word("tail_s4", mk(32'h0000_E400, 32'h0001_EBFF, 32'h0000_E3FF, 32'h0001_0FFF), 8'd4, 1'b1,
                  pk(13'd15, 13'h1FF1, 13'd15, 13'd0));
        send_word("reject_tail", mk(32'h0000_EC00, 32'h0, 32'h0, 32'h0), 8'd4, 1'b0, '0);
        send_word("reject_ffff", mk(32'h0, 32'h0, 32'h0000_FFFF, 32'h0), 8'd4, 1'b0, '0);
        send_word("sig0", mk(32'h0000_4000, 32'h0001_C800, 32'h0000_3FFF, 32'h0001_FBFE), 8'd0, 1'b1,
                  pk(13'd1, 13'h1FFD, 13'd0, 13'h1FF1));
        send_word("sig1", mk(32'h0000_4000, 32'h0001_C800, 32'h0000_3FFF, 32'h0001_FBFE), 8'd1, 1'b1,
                  pk(13'd1, 13'h1FFD, 13'd0, 13'h1FF1));
        send_word("sig9", mk(32'h0000_0800, 32'h0001_7FFF, 32'h0000_EFFF, 32'h0001_0000), 8'd9, 1'b1,
                  pk(13'd1, 13'h1FF8, 13'd15, 13'd0));
        send_word("sig8", mk(32'h0000_0800, 32'h0001_7FFF, 32'h0000_EFFF, 32'h0001_0000), 8'd8, 1'b1,
                  pk(13'd1, 13'h1FF8, 13'd15, 13'd0));
        send_word("tail_wrap", mk(32'h0000_F000, 32'h0, 32'h0, 32'h0), 8'd9, 1'b0, '0);

        // Back-to-back words.
        @(negedge clk);
        random_in = mk(32'h0000_3000, 32'h0, 32'h0, 32'h0);
        sigma = 8'd4;
        random_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_a_valid", 64'(sample_valid), 64'd1);
        check("b2b_a_coeffs", 64'(coeffs), 64'(pk(13'd2, 13'd0, 13'd0, 13'd0)));
        @(negedge clk);
        random_in = mk(32'h0, 32'h0001_5000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        random_valid = 1'b0;
        check("b2b_b_valid", 64'(sample_valid), 64'd1);
        check("b2b_b_coeffs", 64'(coeffs), 64'(pk(13'd0, 13'h1FFD, 13'd0, 13'd0)));
        last_c = pk(13'd0, 13'h1FFD, 13'd0, 13'd0);
        @(posedge clk);
        #1;
        check("b2b_idle", 64'(sample_valid), 64'd0);

        for (int w = 0; w < 13; w++) begin
            ok = 1'b1;
            ec = '0;
            for (int l = 0; l < 4; l++) begin
                lanes[l] = $urandom;
                r = ref_lane4(lanes[l]);
                ok = ok & r[13];
                ec[13*l +: 13] = r[12:0];
            end
            send_word($sformatf("stream%0d", w), mk(lanes[0], lanes[1], lanes[2], lanes[3]), 8'd4, ok, ec);
        end

        @(negedge clk);
        random_in = mk(32'h0000_3000, 32'h0000_5000, 32'h0, 32'h0);
        sigma = 8'd4;
        random_valid = 1'b1;
        @(posedge clk);
        #1;
        random_valid = 1'b0;
        check("pre_rst_valid", 64'(sample_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(sample_valid), 64'd0);
        check("mid_rst_coeffs", 64'(coeffs), 64'd0);
        check("mid_rst_ready", 64'(random_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_c = '0;
        send_word("post_rst_reject", mk(32'h0000_FFFF, 32'h0, 32'h0, 32'h0), 8'd4, 1'b0, '0);
        send_word("post_rst", mk(32'h0001_1000, 32'h0, 32'h0, 32'h0000_8400), 8'd4, 1'b1,
                  pk(13'h1FFF, 13'd0, 13'd0, 13'd5));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
